// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned BE_W  = LANES;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_e;

  // One-hot byte enable for a single byte lane.
  function automatic logic [BE_W-1:0] lane_onehot(input logic [1:0] lane);
    return BE_W'(1'b1) << lane;
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: byte enables, store-byte replication and load-byte extraction.
module mem_byte_lane
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              byte_op_i,
  input  logic [1:0]        lane_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [BE_W-1:0]   be_c_o,
  output logic [DATA_W-1:0] wdata_c_o,
  output logic [DATA_W-1:0] rdata_c_o
);

  // Word ops pass straight through; byte ops select/replicate a single lane.
  always_comb begin
    be_c_o    = BE_WORD;
    wdata_c_o = wdata_i;
    rdata_c_o = rdata_i;
    if (byte_op_i) begin
      be_c_o    = lane_onehot(lane_i);
      wdata_c_o = DATA_W'({LANES{wdata_i[7:0]}});
      rdata_c_o = DATA_W'(rdata_i[{lane_i, 3'b000} +: 8]);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-ported unified memory between instruction fetch
// and the data path. One transaction at a time: IDLE -> BUSY -> RESP.
// Optional watchdog: define MEM_PORT_ARBITER_TIMEOUT_EN to add the TIMEOUT
// parameter and the err output; otherwise BUSY waits for mem_ack indefinitely.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  output logic              err,
`endif
  output logic              hold,
  output logic              unhold
);

  state_e              state_q, state_d;
  grant_e              grant_q, grant_d;
  grant_e              last_q, last_d;
  logic                we_q, we_d;
  logic                byte_q, byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic [BE_W-1:0]     lane_be;
  logic [DATA_W-1:0]   lane_wdata;
  logic [DATA_W-1:0]   lane_rdata;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tout_q, tout_d;
`endif

  mem_byte_lane #(
    .DATA_W (DATA_W)
  ) u_byte_lane (
    .byte_op_i (byte_q),
    .lane_i    (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_c_o    (lane_be),
    .wdata_c_o (lane_wdata),
    .rdata_c_o (lane_rdata)
  );

  // Next-state: arbitration in IDLE, wait for ack (or watchdog) in BUSY, one-cycle RESP.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    we_d       = we_q;
    byte_d     = byte_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    cnt_d      = cnt_q;
    tout_d     = tout_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req && (!if_req || (last_q != DATA))) begin
          grant_d = DATA;
          we_d    = d_we;
          byte_d  = d_byte;
          addr_d  = d_addr;
          wdata_d = d_we ? d_wdata : '0;
          state_d = BUSY;
        end else if (if_req) begin
          grant_d = FETCH;
          we_d    = 1'b0;
          byte_d  = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          state_d = BUSY;
        end
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        cnt_d  = '0;
        tout_d = 1'b0;
`endif
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = RESP;
          if (grant_q == FETCH) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = lane_rdata;
          end
        end
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          tout_d  = 1'b1;
          if (grant_q == FETCH) begin
            if_rdata_d = '0;
          end else begin
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= FETCH;
      last_q     <= FETCH;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      cnt_q      <= '0;
      tout_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      we_q       <= we_d;
      byte_q     <= byte_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tout_q     <= tout_d;
`endif
    end
  end

  // Memory side is driven only in BUSY, from the latched copy.
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? lane_be : '0;
  assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? lane_wdata : '0;

  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = (state_q == RESP) && (grant_q == FETCH);
  assign d_done    = (state_q == RESP) && (grant_q == DATA);
  assign unhold    = d_done;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  assign err       = (state_q == RESP) && tout_q;
`endif

  // Stall the pipeline as soon as the data path asks, and while anything is in flight.
  assign hold      = d_req | (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a memory responder and a done scoreboard.
// Define MEM_PORT_ARBITER_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=8).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic        d_byte;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        hold;
  logic        unhold;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  logic        err;
`endif

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    logic        chk_rdata;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32)
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    ,
    .TIMEOUT (8)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_byte    (d_byte),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    .err       (err),
`endif
    .hold      (hold),
    .unhold    (unhold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check1(tag, |{if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_be,
                  mem_addr, mem_wdata, hold, unhold}, 1'b0);
  endtask

  task automatic push_exp(input logic is_data, input logic [31:0] rdata, input logic chk);
    exp_t e;
    e.is_data   = is_data;
    e.rdata     = rdata;
    e.chk_rdata = chk;
    sb.push_back(e);
  endtask

  // Wait (bounded) for mem_req, check the request, ack after 'delay' cycles, check done.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input logic [31:0] rdata, input int delay);
    exp_t e;
    int   waited;
    waited = 0;
    while (!mem_req && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check1({tag, " mem_req"}, mem_req, 1'b1);
    check32({tag, " mem_addr"}, mem_addr, exp_addr);
    check1({tag, " mem_we"}, mem_we, exp_we);
    check32({tag, " mem_be"}, 32'(mem_be), 32'(exp_be));
    check32({tag, " mem_wdata"}, mem_wdata, exp_wdata);
    check1({tag, " hold busy"}, hold, 1'b1);
    check1({tag, " unhold busy"}, unhold, 1'b0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check1({tag, " mem_req held"}, mem_req, 1'b1);
      check32({tag, " mem_addr held"}, mem_addr, exp_addr);
      check32({tag, " mem_wdata held"}, mem_wdata, exp_wdata);
    end
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    check1({tag, " sb nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check1({tag, " if_done"}, if_done, !e.is_data);
      check1({tag, " d_done"}, d_done, e.is_data);
      check1({tag, " unhold"}, unhold, e.is_data);
      check1({tag, " hold resp"}, hold, 1'b1);
      check1({tag, " mem_req resp"}, mem_req, 1'b0);
      if (e.chk_rdata) begin
        check32({tag, " rdata"}, e.is_data ? d_rdata : if_rdata, e.rdata);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_byte    = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    check_all_zero("reset outputs");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post-reset idle");

    // 1: fetch only, ack two cycles into BUSY
    if_addr = 32'h100;
    if_req  = 1'b1;
    push_exp(1'b0, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check1("t1 mem_req latency", mem_req, 1'b1);
    serve("t1", 32'h100, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 2);
    if_req = 1'b0;
    @(negedge clk);
    check1("t1 hold idle", hold, 1'b0);
    check1("t1 if_done drop", if_done, 1'b0);
    check32("t1 if_rdata held", if_rdata, 32'hDEADBEEF);

    // 2: contention with both requests held: D, F, D, F
    d_we    = 1'b0;
    d_byte  = 1'b0;
    d_addr  = 32'h300;
    if_addr = 32'h400;
    d_req   = 1'b1;
    if_req  = 1'b1;
    push_exp(1'b1, 32'hA0000001, 1'b1);
    push_exp(1'b0, 32'hB0000002, 1'b1);
    push_exp(1'b1, 32'hA0000003, 1'b1);
    push_exp(1'b0, 32'hB0000004, 1'b1);
    serve("t2 D0", 32'h300, 1'b0, 4'b1111, 32'h0, 32'hA0000001, 0);
    serve("t2 F0", 32'h400, 1'b0, 4'b1111, 32'h0, 32'hB0000002, 1);
    serve("t2 D1", 32'h300, 1'b0, 4'b1111, 32'h0, 32'hA0000003, 0);
    serve("t2 F1", 32'h400, 1'b0, 4'b1111, 32'h0, 32'hB0000004, 0);
    d_req  = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    check32("t2 d_rdata held", d_rdata, 32'hA0000003);

    // 3: STB to lane 3, hold rises combinationally with d_req
    d_addr  = 32'h203;
    d_wdata = 32'h000000A5;
    d_we    = 1'b1;
    d_byte  = 1'b1;
    d_req   = 1'b1;
    #1;
    check1("t3 hold comb", hold, 1'b1);
    push_exp(1'b1, 32'h0, 1'b0);
    serve("t3 STB", 32'h200, 1'b1, 4'b1000, 32'hA5A5A5A5, 32'h0, 1);
    d_req = 1'b0;
    @(negedge clk);

    // 4: LBD lane 1, LBD lane 0, misaligned LDW, STW
    d_we    = 1'b0;
    d_byte  = 1'b1;
    d_addr  = 32'h201;
    d_wdata = 32'hFFFFFFFF;
    d_req   = 1'b1;
    push_exp(1'b1, 32'h00000033, 1'b1);
    serve("t4 LBD1", 32'h200, 1'b0, 4'b0010, 32'h0, 32'h11223344, 0);
    d_req = 1'b0;
    @(negedge clk);
    d_addr = 32'h204;
    d_req  = 1'b1;
    push_exp(1'b1, 32'h00000044, 1'b1);
    serve("t4 LBD0", 32'h204, 1'b0, 4'b0001, 32'h0, 32'h11223344, 1);
    d_req = 1'b0;
    @(negedge clk);
    d_byte = 1'b0;
    d_addr = 32'h307;
    d_req  = 1'b1;
    push_exp(1'b1, 32'hCAFEF00D, 1'b1);
    serve("t4 LDW mis", 32'h304, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D, 0);
    d_req = 1'b0;
    @(negedge clk);
    d_we    = 1'b1;
    d_addr  = 32'h40A;
    d_wdata = 32'h12345678;
    d_req   = 1'b1;
    push_exp(1'b1, 32'h0, 1'b0);
    serve("t4 STW", 32'h408, 1'b1, 4'b1111, 32'h12345678, 32'h0, 0);
    d_req = 1'b0;
    @(negedge clk);
    check32("t4 d_rdata after store", d_rdata, 32'hCAFEF00D);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    // 6: watchdog with no ack
    d_we   = 1'b0;
    d_addr = 32'h600;
    d_req  = 1'b1;
    @(negedge clk);
    check1("t6 mem_req", mem_req, 1'b1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check1("t6 busy mem_req", mem_req, 1'b1);
      check1("t6 busy err", err, 1'b0);
    end
    @(negedge clk);
    check1("t6 err", err, 1'b1);
    check1("t6 d_done", d_done, 1'b1);
    check1("t6 mem_req dropped", mem_req, 1'b0);
    check32("t6 d_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    @(negedge clk);
    check1("t6 err drop", err, 1'b0);
`endif

    // 5: reset during BUSY, late ack afterwards
    d_we   = 1'b0;
    d_addr = 32'h500;
    d_req  = 1'b1;
    @(negedge clk);
    check1("t5 mem_req before rst", mem_req, 1'b1);
    rst   = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    check1("t5 mem_req in rst", mem_req, 1'b0);
    check_all_zero("t5 outputs in rst");
    rst = 1'b0;
    @(negedge clk);
    mem_rdata = 32'h55555555;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_all_zero("t5 late ack ignored");
    @(negedge clk);
    check_all_zero("t5 still idle");

    // Arbiter still functional after reset: fetch wins a lone request
    if_addr = 32'h104;
    if_req  = 1'b1;
    push_exp(1'b0, 32'h0BADF00D, 1'b1);
    @(negedge clk);
    check1("t5 refetch latency", mem_req, 1'b1);
    serve("t5 refetch", 32'h104, 1'b0, 4'b1111, 32'h0, 32'h0BADF00D, 0);
    if_req = 1'b0;
    @(negedge clk);
    check1("sb drained", sb.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
